rbg_acc_ctrl: RTL



---
 rtl/rbg_acc_ctrl_if.sv | 32 +++
 rtl/rbg_acc_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/rbg_acc_ctrl_if.sv
// Beam-sum valid stream in, accumulator strobes and slot counters out.
// slave: the sequencer. master: the side driving the stream.
interface rbg_acc_ctrl_if #(
  parameter int RBG_IDX_W = 8
);
  logic                 i_tvalid;
  logic [1:0]           i_rbg_size;
  logic                 o_acc_en;
  logic                 o_acc_load;
  logic                 o_sum_capture;
  logic                 o_rbg_partial;
  logic                 o_acc_clr;
  logic [RBG_IDX_W-1:0] o_rbg_idx;
  logic [1:0]           o_blk_num;
  logic [2:0]           o_sym_num;
  logic                 o_sym_done;
  logic                 o_sym1_done;
  logic                 o_cfg_err;
  logic                 o_busy;

  modport master (
    output i_tvalid, i_rbg_size,
    input  o_acc_en, o_acc_load, o_sum_capture, o_rbg_partial, o_acc_clr, o_rbg_idx,
           o_blk_num, o_sym_num, o_sym_done, o_sym1_done, o_cfg_err, o_busy
  );

  modport slave (
    input  i_tvalid, i_rbg_size,
    output o_acc_en, o_acc_load, o_sum_capture, o_rbg_partial, o_acc_clr, o_rbg_idx,
           o_blk_num, o_sym_num, o_sym_done, o_sym1_done, o_cfg_err, o_busy
  );
endinterface

// File: rtl/rbg_acc_ctrl.sv
// Sequencer for the per-beam RBG accumulators: load/enable/capture/clear strobes plus block/symbol tracking.
// Optional feature macro RBG_ACC_CTRL_PARTIAL_FLUSH_EN: capture a partial RBG at block end instead of dropping it.
module rbg_acc_ctrl #(
  parameter int BLK_PER_SYM = 4,
  parameter int NUM_SYM     = 7,
  parameter int RE_CNT_W    = 16,
  parameter int RBG_IDX_W   = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  rbg_acc_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam logic [1:0]           BLK_LAST = 2'(BLK_PER_SYM - 1);
  localparam logic [2:0]           SYM_LAST = 3'(NUM_SYM - 1);
  localparam logic [RBG_IDX_W-1:0] IDX_MAX  = '1;

  state_t               state_reg;
  logic [RE_CNT_W-1:0]  re_cnt_reg;
  logic [RE_CNT_W-1:0]  n_last_reg;
  logic [RBG_IDX_W-1:0] rbg_idx_reg;
  logic [RBG_IDX_W-1:0] cap_idx_reg;
  logic [RBG_IDX_W-1:0] idx_out_reg;
  logic                 cap_pend_reg;
  logic                 acc_en_reg;
  logic                 acc_load_reg;
  logic                 sum_capture_reg;
  logic                 rbg_partial_reg;
  logic                 acc_clr_reg;
  logic [1:0]           blk_num_reg;
  logic [2:0]           sym_num_reg;
  logic                 sym_done_reg;
  logic                 sym1_done_reg;
  logic                 cfg_err_reg;
  logic                 busy_reg;
  logic [RBG_IDX_W-1:0] rbg_idx_inc;

  assign rbg_idx_inc = (rbg_idx_reg == IDX_MAX) ? rbg_idx_reg : rbg_idx_reg + RBG_IDX_W'(1);

  // Last RE count of an RBG; code 11 falls back to 48 and raises the config error.
  function automatic logic [RE_CNT_W-1:0] rbg_last(input logic [1:0] code);
    case (code)
      2'b01:   rbg_last = RE_CNT_W'(95);
      2'b10:   rbg_last = RE_CNT_W'(191);
      default: rbg_last = RE_CNT_W'(47);
    endcase
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg       <= IDLE;
      re_cnt_reg      <= '0;
      n_last_reg      <= '0;
      rbg_idx_reg     <= '0;
      cap_idx_reg     <= '0;
      idx_out_reg     <= '0;
      cap_pend_reg    <= 1'b0;
      acc_en_reg      <= 1'b0;
      acc_load_reg    <= 1'b0;
      sum_capture_reg <= 1'b0;
      rbg_partial_reg <= 1'b0;
      acc_clr_reg     <= 1'b0;
      blk_num_reg     <= '0;
      sym_num_reg     <= '0;
      sym_done_reg    <= 1'b0;
      sym1_done_reg   <= 1'b0;
      cfg_err_reg     <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      acc_en_reg      <= 1'b0;
      acc_load_reg    <= 1'b0;
      rbg_partial_reg <= 1'b0;
      acc_clr_reg     <= 1'b0;
      sym_done_reg    <= 1'b0;
      cap_pend_reg    <= 1'b0;
      // Full-RBG capture is one cycle behind the last RE so the accumulator has absorbed it.
      sum_capture_reg <= cap_pend_reg;
      if (cap_pend_reg) begin
        idx_out_reg <= cap_idx_reg;
      end

      case (state_reg)
        IDLE: begin
          if (bus.i_tvalid) begin
            state_reg    <= RUN;
            busy_reg     <= 1'b1;
            n_last_reg   <= rbg_last(bus.i_rbg_size);
            if (bus.i_rbg_size == 2'b11) begin
              cfg_err_reg <= 1'b1;
            end
            acc_en_reg   <= 1'b1;
            acc_load_reg <= 1'b1;
            re_cnt_reg   <= RE_CNT_W'(1);
            rbg_idx_reg  <= '0;
          end
        end

        RUN: begin
          if (bus.i_tvalid) begin
            acc_en_reg   <= 1'b1;
            acc_load_reg <= (re_cnt_reg == '0);
            if (re_cnt_reg == n_last_reg) begin
              re_cnt_reg   <= '0;
              cap_pend_reg <= 1'b1;
              cap_idx_reg  <= rbg_idx_reg;
              rbg_idx_reg  <= rbg_idx_inc;
            end else begin
              re_cnt_reg <= re_cnt_reg + RE_CNT_W'(1);
            end
          end else begin
            state_reg   <= FLUSH;
            acc_clr_reg <= 1'b1;
`ifdef RBG_ACC_CTRL_PARTIAL_FLUSH_EN
            if (re_cnt_reg != '0) begin
              sum_capture_reg <= 1'b1;
              rbg_partial_reg <= 1'b1;
              idx_out_reg     <= rbg_idx_reg;
              rbg_idx_reg     <= rbg_idx_inc;
            end
`endif
            if (blk_num_reg == BLK_LAST) begin
              blk_num_reg  <= '0;
              sym_done_reg <= 1'b1;
              sym_num_reg  <= (sym_num_reg == SYM_LAST) ? 3'd0 : sym_num_reg + 3'd1;
              if (sym_num_reg == 3'd0) begin
                sym1_done_reg <= 1'b1;
              end
            end else begin
              blk_num_reg <= blk_num_reg + 2'd1;
            end
          end
        end

        FLUSH: begin
          // Valid during this cycle is a protocol violation and is dropped.
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_acc_en      = acc_en_reg;
  assign bus.o_acc_load    = acc_load_reg;
  assign bus.o_sum_capture = sum_capture_reg;
  assign bus.o_rbg_partial = rbg_partial_reg;
  assign bus.o_acc_clr     = acc_clr_reg;
  assign bus.o_rbg_idx     = idx_out_reg;
  assign bus.o_blk_num     = blk_num_reg;
  assign bus.o_sym_num     = sym_num_reg;
  assign bus.o_sym_done    = sym_done_reg;
  assign bus.o_sym1_done   = sym1_done_reg;
  assign bus.o_cfg_err     = cfg_err_reg;
  assign bus.o_busy        = busy_reg;
endmodule
